// File: rtl/fft_dit_scheduler_if.sv
// Control/handshake bundle between the FFT controller, twiddle ROM, butterfly datapath and the DIT scheduler.
interface fft_dit_scheduler_if #(
  parameter int LOG_N = 5
);
  logic             start;
  logic             busy;
  logic             done;
  logic [LOG_N-2:0] tf_addr;
  logic             tf_addr_nd;
  logic             bf_ready;
  logic             bf_valid;
  logic [LOG_N-1:0] bf_idx_a;
  logic [LOG_N-1:0] bf_idx_b;
  logic [2:0]       bf_stage;
  logic             bf_last;

  modport master (
    input  start, bf_ready,
    output busy, done, tf_addr, tf_addr_nd,
           bf_valid, bf_idx_a, bf_idx_b, bf_stage, bf_last
  );

  modport slave (
    output start, bf_ready,
    input  busy, done, tf_addr, tf_addr_nd,
           bf_valid, bf_idx_a, bf_idx_b, bf_stage, bf_last
  );
endinterface

// File: rtl/fft_dit_scheduler.sv
// Radix-2 DIT pass sequencer: ROM strobe now, operand beat 1 cycle later; bf_ready=0 in ISSUE stalls
// the butterfly counter (bubble), and each stage ends with a BF_LATENCY+1 cycle drain that ignores bf_ready.
module fft_dit_scheduler #(
  parameter int N          = 32,
  parameter int LOG_N      = 5,
  parameter int BF_LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst,
  fft_dit_scheduler_if.master bus
);
  localparam int            BW     = LOG_N - 1;
  localparam int            DW     = $clog2(BF_LATENCY + 2);
  localparam logic [BW-1:0] B_LAST = BW'(N / 2 - 1);
  localparam logic [2:0]    S_LAST = 3'(LOG_N - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       stage, stage_nxt;
  logic [BW-1:0]    bfly, bfly_nxt;
  logic [DW-1:0]    drain_cnt, drain_nxt;
  logic             issue;

  logic [BW-1:0]    mask, j, tf_calc, tf_q;
  logic [LOG_N-1:0] span, idx_a, idx_b;
  logic             vld_q, last_q;
  logic [LOG_N-1:0] a_q, b_q;
  logic [2:0]       stage_q;

  // On the final stage the mask shift overflows to zero, so the subtraction yields all ones.
  assign mask    = (BW'(1) << stage) - BW'(1);
  assign j       = bfly & mask;
  assign span    = LOG_N'(1) << stage;
  assign idx_a   = (({1'b0, bfly} >> stage) << (stage + 3'd1)) | {1'b0, j};
  assign idx_b   = idx_a + span;
  assign tf_calc = j << (S_LAST - stage);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stage     <= '0;
      bfly      <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      stage     <= stage_nxt;
      bfly      <= bfly_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    bfly_nxt  = bfly;
    drain_nxt = drain_cnt;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = ISSUE;
          stage_nxt = '0;
          bfly_nxt  = '0;
        end
      end
      ISSUE: begin
        if (bus.bf_ready) begin
          issue    = 1'b1;
          bfly_nxt = bfly + BW'(1);
          if (bfly == B_LAST) begin
            bfly_nxt  = '0;
            drain_nxt = DW'(BF_LATENCY);
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          if (stage == S_LAST) begin
            state_nxt = DONE;
          end else begin
            stage_nxt = stage + 3'd1;
            state_nxt = ISSUE;
          end
        end else begin
          drain_nxt = drain_cnt - DW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand beat registers line up with the twiddle ROM's registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      stage_q <= '0;
      tf_q    <= '0;
    end else begin
      vld_q  <= issue;
      last_q <= issue && (bfly == B_LAST);
      if (issue) begin
        a_q     <= idx_a;
        b_q     <= idx_b;
        stage_q <= stage;
        tf_q    <= tf_calc;
      end
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.tf_addr_nd = issue;
  assign bus.tf_addr    = issue ? tf_calc : tf_q;
  assign bus.bf_valid   = vld_q;
  assign bus.bf_idx_a   = a_q;
  assign bus.bf_idx_b   = b_q;
  assign bus.bf_stage   = stage_q;
  assign bus.bf_last    = last_q;
endmodule

// File: tb/tb_fft_dit_scheduler.sv
// Self-checking bench: transaction-level DIT model (group/offset loops) plus cycle-window expectations.
module tb_fft_dit_scheduler;
  localparam int N          = 32;
  localparam int LOG_N      = 5;
  localparam int BF_LATENCY = 4;
  localparam int HALF       = N / 2;
  localparam int TOTAL      = LOG_N * HALF;
  localparam int RUN_CYC    = LOG_N * (HALF + BF_LATENCY + 1) + 1;

  logic clk = 1'b0;
  logic rst;

  fft_dit_scheduler_if #(.LOG_N(LOG_N)) bus ();

  fft_dit_scheduler #(.N(N), .LOG_N(LOG_N), .BF_LATENCY(BF_LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {int a; int b; int st; int last; int tw;} beat_t;
  beat_t beats[TOTAL];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int n         = 0;
  bit active    = 1'b0;
  int p         = 0;
  int gate      = 0;
  int done_at   = -1;
  bit pend_vld  = 1'b0;
  int pend      = 0;
  int last_tw   = 0;
  int hold_a    = 0;
  int hold_b    = 0;
  int start_cyc = 0;
  int stalls    = 0;

  // Observations of the current run
  int seen, last_seen, dones, done_cyc, drain_nd;
  int stage_cnt[8];
  int obs_a[TOTAL];
  int obs_b[TOTAL];
  int obs_tw[TOTAL];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic rdy, input logic rs);
    bit exp_nd, exp_done, in_drain;
    bus.start    = st;
    bus.bf_ready = rdy;
    rst          = rs;
    #3;
    exp_nd   = active && (p < TOTAL) && (n >= gate) && (rdy === 1'b1);
    exp_done = active && (n == done_at);
    in_drain = active && (p > 0) && !exp_done && ((n < gate) || (p == TOTAL));

    chk("busy", 32'(bus.busy), 32'(active));
    chk("done", 32'(bus.done), 32'(exp_done));
    chk("tf_addr_nd", 32'(bus.tf_addr_nd), 32'(exp_nd));
    chk("bf_valid", 32'(bus.bf_valid), 32'(pend_vld));
    if (exp_nd) begin
      chk("tf_addr", 32'(bus.tf_addr), beats[p].tw);
      obs_tw[p] = int'(bus.tf_addr);
    end else begin
      chk("tf_addr_hold", 32'(bus.tf_addr), last_tw);
    end
    if (pend_vld) begin
      chk("bf_idx_a", 32'(bus.bf_idx_a), beats[pend].a);
      chk("bf_idx_b", 32'(bus.bf_idx_b), beats[pend].b);
      chk("bf_stage", 32'(bus.bf_stage), beats[pend].st);
      chk("bf_last", 32'(bus.bf_last), beats[pend].last);
      obs_a[pend] = int'(bus.bf_idx_a);
      obs_b[pend] = int'(bus.bf_idx_b);
      hold_a = beats[pend].a;
      hold_b = beats[pend].b;
    end else begin
      chk("idx_a_hold", 32'(bus.bf_idx_a), hold_a);
      chk("idx_b_hold", 32'(bus.bf_idx_b), hold_b);
    end

    if (bus.bf_valid === 1'b1) begin
      seen++;
      if (bus.bf_last === 1'b1) last_seen++;
      if (!$isunknown(bus.bf_stage)) stage_cnt[bus.bf_stage]++;
    end
    if (bus.done === 1'b1) begin
      dones++;
      done_cyc = n;
    end
    if (in_drain && bus.tf_addr_nd === 1'b1) drain_nd++;

    if (rs) begin
      active   = 1'b0;
      pend_vld = 1'b0;
      done_at  = -1;
      last_tw  = 0;
      hold_a   = 0;
      hold_b   = 0;
    end else begin
      pend_vld = exp_nd;
      pend     = p;
      if (exp_nd) begin
        last_tw = beats[p].tw;
        if (p % HALF == HALF - 1) gate = n + BF_LATENCY + 2;
        if (p == TOTAL - 1) done_at = n + BF_LATENCY + 2;
        p++;
      end else if (active && (p < TOTAL) && (n >= gate)) begin
        stalls++;
      end
      if (exp_done) begin
        active  = 1'b0;
        done_at = -1;
      end else if (!active && st) begin
        active    = 1'b1;
        p         = 0;
        gate      = n + 1;
        start_cyc = n;
        stalls    = 0;
      end
    end
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic clear_obs();
    seen = 0; last_seen = 0; dones = 0; done_cyc = -1; drain_nd = 0;
    for (int s = 0; s < 8; s++) stage_cnt[s] = 0;
  endtask

  // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready, 3 ready high with stray starts
  task automatic go(input int mode);
    int k;
    logic rdy, st;
    clear_obs();
    cyc(1'b1, 1'b1, 1'b0);
    k = 1;
    while (active && k < 1000) begin
      case (mode)
        1:       rdy = (k % 4 == 1) || (k % 4 == 0);
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      st = (mode == 3) && (k == 25 || k == 40);
      cyc(st, rdy, 1'b0);
      k++;
    end
    chk("run_terminated", 32'(active), 32'd0);
    chk("beat_count", seen, TOTAL);
    chk("last_count", last_seen, LOG_N);
    for (int s = 0; s < LOG_N; s++) chk("stage_beats", stage_cnt[s], HALF);
    chk("done_pulses", dones, 1);
    chk("done_latency", done_cyc - start_cyc, RUN_CYC + stalls);
    chk("drain_strobes", drain_nd, 0);
  endtask

  initial begin
    int idx, k, tw_or;
    idx = 0;
    for (int s = 0; s < LOG_N; s++)
      for (int g = 0; g < N; g += (2 << s))
        for (int o = 0; o < (1 << s); o++) begin
          beats[idx] = '{g + o, g + o + (1 << s), s, int'(idx % HALF == HALF - 1), o * (N >> (s + 1))};
          idx++;
        end

    rst = 1'b1;
    bus.start = 1'b0;
    bus.bf_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held, then idle with random ready: nothing may move
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (6) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);

    // Full run, ready high, with index/twiddle spot checks
    go(0);
    tw_or = 0;
    for (int i = 0; i < HALF; i++) tw_or |= obs_tw[i];
    chk("spot_s0_tw_all_zero", tw_or, 0);
    chk("spot_s0b3_a", obs_a[3], 6);
    chk("spot_s0b3_b", obs_b[3], 7);
    chk("spot_s1b3_a", obs_a[HALF + 3], 5);
    chk("spot_s1b3_b", obs_b[HALF + 3], 7);
    chk("spot_s1b3_tw", obs_tw[HALF + 3], 8);
    chk("spot_s4b5_a", obs_a[4 * HALF + 5], 5);
    chk("spot_s4b5_b", obs_b[4 * HALF + 5], 21);
    chk("spot_s4b5_tw", obs_tw[4 * HALF + 5], 5);

    repeat ($urandom_range(1, 5)) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);

    // Backpressure pattern 1,0,0,1
    go(1);
    chk("bp_stalls_seen", 32'(stalls > 0), 32'd1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // Stray start pulses in stage 1 issue and in a drain
    go(3);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);

    // Abort at stage 2, b=7
    clear_obs();
    cyc(1'b1, 1'b1, 1'b0);
    k = 0;
    while (!(active && p == 2 * HALF + 7) && k < 300) begin
      cyc(1'b0, 1'b1, 1'b0);
      k++;
    end
    chk("abort_point_reached", p, 2 * HALF + 7);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (10) cyc(1'b0, 1'b1, 1'b0);
    chk("abort_no_done", dones, 0);

    // Clean run after the abort, then a randomized-ready run
    go(0);
    repeat ($urandom_range(1, 4)) cyc(1'b0, 1'b0, 1'b0);
    go(2);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_dit_scheduler.md
Name: fft_dit_scheduler

Overview:
Sequences one in-place radix-2 decimation-in-time FFT pass over an N-point buffer. For each stage and butterfly it drives the twiddle-factor ROM address/strobe. One cycle later, aligned with the ROM's registered twiddle output, it presents the butterfly operand indices to the butterfly/memory datapath. Between stages it drains the butterfly pipeline so in-place writes land before the next stage's reads. The block sits between the top-level FFT control and the twiddle ROM + butterfly unit.

Parameters:
N, 32, FFT length (power of 2, >= 4)
LOG_N, 5, log2(N); number of stages
BF_LATENCY, 4, butterfly read-to-writeback latency in cycles; sets the drain length

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  begin a transform; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done is asserted (inclusive)
done  out  1  one-cycle pulse when the last stage has drained
tf_addr  out  LOG_N-1  twiddle ROM address
tf_addr_nd  out  1  twiddle ROM read strobe; high only on issue cycles
bf_ready  in  1  butterfly accepts a beat in the cycle after this is sampled high
bf_valid  out  1  operand beat valid; aligned with ROM output (one cycle after tf_addr_nd)
bf_idx_a  out  LOG_N  upper-leg operand index
bf_idx_b  out  LOG_N  lower-leg operand index (bf_idx_a + 2^stage)
bf_stage  out  3  stage number of the current beat
bf_last  out  1  high on the final beat of each stage

Behaviour:
- Reset state: IDLE. All outputs are 0, and the stage counter and butterfly counter are 0.
- Counters:
  - stage s: 0..LOG_N-1.
  - butterfly b: 0..N/2-1.
- Index arithmetic (combinational from s, b):
  - j = b mod 2^s
  - idx_a = ((b >> s) << (s+1)) | j
  - idx_b = idx_a + 2^s
  - tf_addr = j << (LOG_N-1-s), truncated to LOG_N-1 bits.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE:
    - start=1 -> ISSUE, with s=0 and b=0.
    - start=0 -> stay in IDLE.
  - ISSUE, each cycle:
    - If bf_ready=1: drive tf_addr_nd=1 with tf_addr for (s, b), and capture idx_a, idx_b, s and (b==N/2-1) into the one-cycle alignment register. b increments.
    - If bf_ready=0: tf_addr_nd=0, the counters hold, and nothing is issued (a bubble).
    - After issuing b=N/2-1: b wraps to 0 and the state goes to DRAIN.
  - DRAIN:
    - Lasts exactly BF_LATENCY+1 cycles, counted by a down-counter; bf_ready is ignored.
    - At the end: if s==LOG_N-1 -> DONE; otherwise s increments and the state goes to ISSUE.
  - DONE: done=1 for one cycle, then IDLE. busy drops in the following cycle.
- Output pipeline:
  - bf_valid, bf_idx_a, bf_idx_b, bf_stage and bf_last are registers loaded on the issue edge.
  - They are therefore valid in the cycle after tf_addr_nd, matching the ROM's one-cycle latency.
  - bf_valid=0 on non-issue cycles; the index outputs hold their last value.
- tf_addr holds its last value when tf_addr_nd=0, since the ROM keeps its output.
- start while busy is ignored; there is no queuing.
- rst at any point, including mid-stage or mid-drain, aborts the transform: IDLE and all outputs 0 on the next edge. No done is produced.
- Throughput: with bf_ready held high, one butterfly per cycle. Cycles from start-accept edge to done = LOG_N*(N/2 + BF_LATENCY + 1) + 1, which is 106 for the defaults.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, start=0 -> busy, done, tf_addr_nd and bf_valid all 0; FSM stays in IDLE.
2. Full run, bf_ready=1, defaults:
   - exactly 80 bf_valid beats, 16 per stage, each stage's last beat with bf_last=1;
   - done pulses 106 cycles after start is sampled;
   - no tf_addr_nd in any DRAIN cycle (5 per stage).
3. Index/twiddle spot checks:
   - stage 0: every tf_addr=0; b=3 -> a=6, b=7.
   - stage 1, b=3 -> a=5, b=7, tf_addr=8.
   - stage 4, b=5 -> a=5, b=21, tf_addr=5.
   - Each beat's bf_valid occurs one cycle after its tf_addr_nd.
4. Backpressure: bf_ready toggles 1,0,0,1 repeatedly -> no beats lost or duplicated, order unchanged (b strictly increasing), and done is delayed by exactly the number of ISSUE-state bf_ready=0 cycles.
5. Mid-operation reset: assert rst during stage 2, b=7 -> next cycle all outputs 0, no done. A subsequent start yields a clean full run as in scenario 2.
6. start pulsed during busy (stage 1 and in DRAIN) -> ignored; exactly one done and 80 beats.
